// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - tag and grant encodings shared by mem_arbiter and its tag FIFO
package mem_arb_pkg;

  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_LOAD  = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_LOAD,
    GNT_STORE
  } gnt_e;

  function automatic logic is_read(gnt_e g);
    return (g == GNT_FETCH) || (g == GNT_LOAD);
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// rtl/arb_tag_fifo.sv - DEPTH-entry 1-bit in-order tag queue recording which port owns each read
module arb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic tag_i,
  input  logic pop_i,
  output logic tag_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign tag_o   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = tag_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch, load and store ports
// MEM_ARB_RR_EN selects fetch/data round-robin with starvation counters instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DEPTH  = 2,
  parameter int STARVE = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_ready,
  input  logic [AW-1:0] imem_addr,
  output logic          imem_valid,
  output logic          imem_rresp,
  output logic [31:0]   imem_rdata,
  input  logic          dmem_rready,
  input  logic [AW-1:0] dmem_raddr,
  output logic          dmem_rvalid,
  output logic          dmem_rresp,
  output logic [31:0]   dmem_rdata,
  input  logic          dmem_wready,
  input  logic [AW-1:0] dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  output logic          dmem_wvalid,
  output logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_rresp,
  input  logic [31:0]   mem_rdata
);

  gnt_e gnt;
  logic q_full, q_empty, head_tag;
  logic rd_ok, rsp_ok;
  logic protocol_err_q, protocol_err_d;

  // Full is judged on the registered count only; a same-cycle pop never frees a slot.
  assign rd_ok  = !q_full;
  assign rsp_ok = mem_rresp && !q_empty && !reset;

`ifdef MEM_ARB_RR_EN
  localparam int CW = $clog2(STARVE + 1);

  logic          rr_data_q, rr_data_d;
  logic [CW-1:0] f_cnt_q, f_cnt_d;
  logic [CW-1:0] d_cnt_q, d_cnt_d;
  logic          f_elig, d_elig, f_force, d_force, pick_data;
  gnt_e          data_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_data_q <= 1'b0;
      f_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      rr_data_q <= rr_data_d;
      f_cnt_q   <= f_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

  // A starved class wins outright; otherwise the pointer's class goes first and the other fills in.
  always_comb begin
    data_gnt = GNT_NONE;
    if (dmem_wready) begin
      data_gnt = GNT_STORE;
    end else if (dmem_rready && rd_ok) begin
      data_gnt = GNT_LOAD;
    end
    f_elig  = imem_ready && rd_ok;
    d_elig  = (data_gnt != GNT_NONE);
    f_force = f_elig && (f_cnt_q >= CW'(STARVE));
    d_force = d_elig && (d_cnt_q >= CW'(STARVE));
    if (f_force != d_force) begin
      pick_data = d_force;
    end else begin
      pick_data = rr_data_q ? d_elig : !f_elig;
    end
    if (reset) begin
      gnt = GNT_NONE;
    end else if (pick_data) begin
      gnt = data_gnt;
    end else begin
      gnt = f_elig ? GNT_FETCH : GNT_NONE;
    end
  end

  always_comb begin
    rr_data_d = rr_data_q;
    f_cnt_d   = f_cnt_q;
    d_cnt_d   = d_cnt_q;
    if (gnt == GNT_FETCH) begin
      rr_data_d = 1'b1;
    end else if (gnt != GNT_NONE) begin
      rr_data_d = 1'b0;
    end
    if ((gnt == GNT_FETCH) || !imem_ready) begin
      f_cnt_d = '0;
    end else if (f_cnt_q < CW'(STARVE)) begin
      f_cnt_d = f_cnt_q + 1'b1;
    end
    if ((gnt == GNT_LOAD) || (gnt == GNT_STORE) || !(dmem_rready || dmem_wready)) begin
      d_cnt_d = '0;
    end else if (d_cnt_q < CW'(STARVE)) begin
      d_cnt_d = d_cnt_q + 1'b1;
    end
  end
`else
  logic unused_starve;
  assign unused_starve = (STARVE > 0);

  always_comb begin
    if (reset) begin
      gnt = GNT_NONE;
    end else if (dmem_wready) begin
      gnt = GNT_STORE;
    end else if (dmem_rready && rd_ok) begin
      gnt = GNT_LOAD;
    end else if (imem_ready && rd_ok) begin
      gnt = GNT_FETCH;
    end else begin
      gnt = GNT_NONE;
    end
  end
`endif

  always_comb begin
    imem_valid  = (gnt == GNT_FETCH);
    dmem_rvalid = (gnt == GNT_LOAD);
    dmem_wvalid = (gnt == GNT_STORE);
    mem_ready   = (gnt != GNT_NONE);
    mem_we      = (gnt == GNT_STORE);
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    case (gnt)
      GNT_FETCH: mem_addr = imem_addr;
      GNT_LOAD:  mem_addr = dmem_raddr;
      GNT_STORE: begin
        mem_addr  = dmem_waddr;
        mem_wdata = dmem_wdata;
        mem_wstrb = dmem_wstrb;
      end
      default: mem_addr = '0;
    endcase
  end

  always_comb begin
    imem_rresp = rsp_ok && (head_tag == TAG_FETCH);
    dmem_rresp = rsp_ok && (head_tag == TAG_LOAD);
    imem_rdata = rsp_ok ? mem_rdata : 32'h0;
    dmem_rdata = rsp_ok ? mem_rdata : 32'h0;
  end

  arb_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (is_read(gnt)),
    .tag_i   ((gnt == GNT_LOAD) ? TAG_LOAD : TAG_FETCH),
    .pop_i   (rsp_ok),
    .tag_o   (head_tag),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Sticky record of a response arriving with nothing outstanding.
  always_comb begin
    protocol_err_d = protocol_err_q;
    if (mem_rresp && q_empty) begin
      protocol_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_err_q <= 1'b0;
    end else begin
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule
